frame_buffer_writer: RTL
========================

FRAME_BUFFER_WRITER -- requirements
Module: frame_buffer_writer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 8, pixel width.
- ADDR_WIDTH, 19, SRAM address width.
- XRES, 640, pixels per line.
- YRES, 480, lines per frame.
- FIFO_DEPTH, 4, input pixel buffer entries (power of 2).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, system clock.
- rst, in, 1, synchronous reset, active-low.
- clk_en, in, 1, pixel-rate enable; the FSM advances only when 1.
- video_off, in, 1, VGA blanking; the SRAM bus is free for writes.
- pix_data, in, DATA_WIDTH, input pixel.
- pix_valid, in, 1, pixel present.
- pix_ready, out, 1, pixel accepted when valid&ready.
- pix_sof, in, 1, first pixel of frame, qualified by valid.
- pix_eol, in, 1, last pixel of line, qualified by valid.
- addr, out, ADDR_WIDTH, SRAM write address.
- dout, out, DATA_WIDTH, SRAM write data.
- WES, out, 1, SRAM write strobe, active-high.
- bus_oe, out, 1, writer owns the SRAM bus; the top tristates din from this.
- frame_done, out, 1, one-cycle pulse after the last pixel of a frame is written.
- line_err, out, 1, one-cycle pulse on an early or late EOL.
REQ-003 Clock is clk; reset is rst, synchronous, active-low.

Function
REQ-010 Input FIFO: FIFO_DEPTH entries holding {sof, eol, data}.
- pix_ready = !full, combinational from FIFO state.
- A push and pop in the same cycle when the FIFO is full is allowed and leaves the count unchanged.
REQ-011 FSM states: WAIT_SOF, IDLE, SETUP, STROBE, HOLD. All transitions occur only when clk_en=1.
REQ-012 WAIT_SOF:
- Pops and discards FIFO entries with sof=0.
- An entry with sof=1 sets x=0 and line_base=0, and moves to IDLE without popping.
REQ-013 IDLE: when the FIFO is non-empty and video_off=1, latch the head entry, pop it, and go to SETUP.
REQ-014 Latch arithmetic:
- addr = line_base + x, computed at ADDR_WIDTH.
- dout = data.
- If the latched entry has sof=1 while not in WAIT_SOF, force x=0, line_base=0 before computing addr (resync).
REQ-015 SETUP:
- bus_oe=1, WES=0.
- If video_off=0, abort to IDLE and re-present the same latched pixel later, with no strobe.
- Otherwise go to STROBE.
REQ-016 STROBE: bus_oe=1, WES=1 for exactly one enabled cycle, then go to HOLD. This state is not interruptible.
REQ-017 HOLD: bus_oe=1, WES=0, addr and dout held, then advance counters and go to IDLE.
REQ-018 Counter advance in HOLD:
- eol=1 and x=XRES-1: x=0, line_base+=XRES, y+=1.
- eol=1 and x<XRES-1: same as above, plus a line_err pulse.
- eol=0 and x=XRES-1: same as above, plus a line_err pulse (wrap at the line length).
- Otherwise: x+=1.
REQ-019 End of frame:
- When the line advance makes y=YRES, pulse frame_done and go to WAIT_SOF.
- x, y and line_base clear at that point.
REQ-020 Address range: the maximum address is XRES*YRES-1 = 307199. The address never exceeds it and never wraps within a frame.
REQ-021 Bus ownership:
- bus_oe=0 and WES=0 in WAIT_SOF and IDLE.
- addr and dout hold their last values when not driving.
REQ-022 Pulse gating: frame_done and line_err are registered one-cycle pulses, independent of clk_en gating.

Reset
REQ-030 On rst=0 at a clock edge:
- State=WAIT_SOF.
- FIFO is emptied, so pix_ready=1.
- x, y, line_base = 0.
- addr=0, dout=0, WES=0, bus_oe=0, frame_done=0, line_err=0.
REQ-031 Reset mid-write (SETUP, STROBE or HOLD) deasserts WES and bus_oe on the next edge. The in-flight pixel is lost.

Structure
REQ-040 Shared package holds:
- The XRES/YRES defaults.
- The FSM state encoding.
- The FIFO entry layout {sof, eol, data}.
REQ-041 One sub-module, pixel_fifo: a synchronous FIFO parameterized by width and depth, with full/empty outputs. All remaining logic lives in frame_buffer_writer.

Verification
REQ-050 Scenario: reset, then sof pixel 0xA5 with video_off=1 and clk_en=1.
- Response: addr=0, dout=0xA5; WES high exactly one cycle, 2 enabled cycles after the pop; bus_oe high for 3 enabled cycles.
REQ-051 Scenario: full 640x480 frame with eol every 640 pixels.
- Response: the last write is addr=307199; frame_done pulses once; no line_err.
REQ-052 Scenario: eol on x=99 in line 0.
- Response: line_err pulses; the next pixel is written at addr=640.
REQ-053 Scenario: video_off falls during SETUP.
- Response: no WES; the same pixel is written once video_off returns to 1, at the same addr.
REQ-054 Scenario: pix_valid held high with video_off=0.
- Response: pix_ready drops after 4 accepted pixels; no data loss after video_off=1.
REQ-055 Scenario: sof mid-frame at x=10, y=3.
- Response: that pixel is written at addr=0, then normal sequencing resumes.
- Separately: rst=0 during STROBE gives WES=0 on the next edge.

Source files
------------

// File: rtl/frame_buffer_writer_pkg.sv
// Shared definitions for the frame buffer writer: default raster size,
// FSM state encoding and the layout of one buffered pixel entry.
package frame_buffer_writer_pkg;

    localparam int XRES_DEFAULT = 640;
    localparam int YRES_DEFAULT = 480;

    // Write sequencer states.
    typedef enum logic [2:0] {
        ST_WAIT_SOF = 3'd0,
        ST_IDLE     = 3'd1,
        ST_SETUP    = 3'd2,
        ST_STROBE   = 3'd3,
        ST_HOLD     = 3'd4
    } fbw_state_e;

    // A FIFO entry is {sof, eol, data}; the two flag bits sit above the pixel.
    typedef struct packed {
        logic sof;
        logic eol;
    } entry_flags_t;

    localparam int ENTRY_FLAG_BITS = 2;

endpackage

// File: rtl/frame_buffer_writer_pixel_fifo.sv
// Small synchronous FIFO buffering incoming pixels ahead of the SRAM writer.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module pixel_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; a push into a full FIFO is legal only alongside a pop.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/frame_buffer_writer.sv
// Writes a raster pixel stream into an SRAM frame buffer, using the bus only
// while the display side is blanked (video_off=1). Each pixel is written with a
// SETUP / STROBE / HOLD sequence; addresses follow line_base + x.
module frame_buffer_writer
    import frame_buffer_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 19,
    parameter int XRES       = XRES_DEFAULT,
    parameter int YRES       = YRES_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  video_off,
    input  logic [DATA_WIDTH-1:0] pix_data,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic                  pix_sof,
    input  logic                  pix_eol,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  WES,
    output logic                  bus_oe,
    output logic                  frame_done,
    output logic                  line_err
);
    localparam int EW = DATA_WIDTH + ENTRY_FLAG_BITS;
    localparam int XW = (XRES > 1) ? $clog2(XRES) : 1;
    localparam int YW = (YRES > 1) ? $clog2(YRES) : 1;

    logic [EW-1:0]         fifo_rd;
    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    entry_flags_t          head_flags;
    logic [DATA_WIDTH-1:0] head_data;

    fbw_state_e            state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  eol_q, eol_d;
    logic                  pend_q, pend_d;
    logic                  wes_q, wes_d;
    logic                  bus_oe_q, bus_oe_d;
    logic                  frame_done_q, frame_done_d;
    logic                  line_err_q, line_err_d;
    logic                  line_end;

    assign pix_ready  = !fifo_full;
    assign fifo_push  = pix_valid && !fifo_full;
    assign head_flags = entry_flags_t'(fifo_rd[EW-1 -: ENTRY_FLAG_BITS]);
    assign head_data  = fifo_rd[DATA_WIDTH-1:0];
    assign line_end   = (x_q == XW'(XRES - 1));

    pixel_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_pixel_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({pix_sof, pix_eol, pix_data}),
        .dout  (fifo_rd),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, pixel latch, counter advance and registered bus/pulse outputs.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        line_base_d  = line_base_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        eol_d        = eol_q;
        pend_d       = pend_q;
        frame_done_d = 1'b0;
        line_err_d   = 1'b0;
        fifo_pop     = 1'b0;

        case (state_q)
            ST_WAIT_SOF: begin
                if (clk_en && !fifo_empty) begin
                    if (head_flags.sof) begin
                        x_d         = '0;
                        y_d         = '0;
                        line_base_d = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        fifo_pop = 1'b1;
                    end
                end else begin
                    fifo_pop = 1'b0;
                end
            end
            ST_IDLE: begin
                if (clk_en && video_off) begin
                    if (pend_q) begin
                        // Re-present the pixel aborted earlier; addr/dout still hold it.
                        pend_d  = 1'b0;
                        state_d = ST_SETUP;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        dout_d   = head_data;
                        eol_d    = head_flags.eol;
                        state_d  = ST_SETUP;
                        if (head_flags.sof) begin
                            // A new frame starts here: restart the raster from the origin.
                            x_d         = '0;
                            y_d         = '0;
                            line_base_d = '0;
                            addr_d      = '0;
                        end else begin
                            addr_d = line_base_q + ADDR_WIDTH'(x_q);
                        end
                    end else begin
                        fifo_pop = 1'b0;
                    end
                end else begin
                    fifo_pop = 1'b0;
                end
            end
            ST_SETUP: begin
                if (clk_en) begin
                    if (!video_off) begin
                        pend_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_STROBE;
                    end
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_STROBE: begin
                if (clk_en) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_STROBE;
                end
            end
            ST_HOLD: begin
                if (clk_en) begin
                    if (eol_q || line_end) begin
                        // Early EOL, or running off the line end without EOL, is flagged.
                        line_err_d = eol_q ^ line_end;
                        x_d        = '0;
                        if (y_q == YW'(YRES - 1)) begin
                            frame_done_d = 1'b1;
                            y_d          = '0;
                            line_base_d  = '0;
                            state_d      = ST_WAIT_SOF;
                        end else begin
                            y_d         = y_q + YW'(1);
                            line_base_d = line_base_q + ADDR_WIDTH'(XRES);
                            state_d     = ST_IDLE;
                        end
                    end else begin
                        x_d     = x_q + XW'(1);
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_WAIT_SOF;
            end
        endcase

        bus_oe_d = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        wes_d    = (state_d == ST_STROBE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_WAIT_SOF;
            x_q          <= '0;
            y_q          <= '0;
            line_base_q  <= '0;
            addr_q       <= '0;
            dout_q       <= '0;
            eol_q        <= 1'b0;
            pend_q       <= 1'b0;
            wes_q        <= 1'b0;
            bus_oe_q     <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            line_base_q  <= line_base_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            eol_q        <= eol_d;
            pend_q       <= pend_d;
            wes_q        <= wes_d;
            bus_oe_q     <= bus_oe_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
        end
    end

    assign addr       = addr_q;
    assign dout       = dout_q;
    assign WES        = wes_q;
    assign bus_oe     = bus_oe_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;

endmodule
